// File: rtl/gemv_loader_if.sv
// Command, operand-stream and result-stream handshakes of gemv_loader.
// master drives commands/operands and accepts results; slave is the loader.
interface gemv_loader_if #(
  parameter int DW = 16
);
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_load_a;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          res_valid;
  logic          res_ready;
  logic [DW-1:0] res_data;
  logic          res_last;

  modport master (
    output cmd_valid, cmd_load_a,
    output in_valid, in_data,
    output res_ready,
    input  cmd_ready, in_ready,
    input  res_valid, res_data, res_last
  );

  modport slave (
    input  cmd_valid, cmd_load_a,
    input  in_valid, in_data,
    input  res_ready,
    output cmd_ready, in_ready,
    output res_valid, res_data, res_last
  );
endinterface

// File: rtl/gemv_loader.sv
// Operand loader for a GEMV array: streams A and W in, fires the array,
// waits with timeout for its result and drains it element by element.
module gemv_loader #(
  parameter int DW      = 16,
  parameter int SZ      = 3,
  parameter int TIMEOUT = 10
) (
  input  logic          clk,
  input  logic          rst,
  gemv_loader_if.slave  bus,
  output logic [DW-1:0] A_o [SZ*SZ],
  output logic [DW-1:0] W_o [SZ],
  output logic          en_o,
  input  logic          arr_valid_i,
  input  logic [DW-1:0] O_i [SZ],
  output logic          err_o
);
  localparam int N  = SZ * SZ;
  localparam int IW = $clog2(N + 1);
  localparam int AW = (N > 1) ? $clog2(N) : 1;
  localparam int WW = (SZ > 1) ? $clog2(SZ) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [IW-1:0] A_LAST = IW'(N - 1);
  localparam logic [IW-1:0] W_LAST = IW'(SZ - 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD_A,
    LOAD_W,
    FIRE,
    WAIT,
    DRAIN
  } state_t;

  state_t        state;
  logic [IW-1:0] idx;
  logic [TW-1:0] tmr;
  logic          a_loaded;
  logic [DW-1:0] res_buf [SZ];
  logic          cmd_rdy;
  logic          in_rdy;
  logic          res_vld;
  logic          res_lst;

  logic cmd_hs;
  logic in_hs;
  logic res_hs;

  assign cmd_hs = bus.cmd_valid && cmd_rdy;
  assign in_hs  = bus.in_valid && in_rdy;
  assign res_hs = res_vld && bus.res_ready;

  assign bus.cmd_ready = cmd_rdy;
  assign bus.in_ready  = in_rdy;
  assign bus.res_valid = res_vld;
  assign bus.res_last  = res_lst;
  assign bus.res_data  = res_buf[idx[WW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      idx      <= '0;
      tmr      <= '0;
      a_loaded <= 1'b0;
      cmd_rdy  <= 1'b0;
      in_rdy   <= 1'b0;
      res_vld  <= 1'b0;
      res_lst  <= 1'b0;
      en_o     <= 1'b0;
      err_o    <= 1'b0;
      for (int i = 0; i < N; i++)
        A_o[i] <= '0;
      for (int i = 0; i < SZ; i++) begin
        W_o[i]     <= '0;
        res_buf[i] <= '0;
      end
    end else begin
      en_o  <= 1'b0;
      err_o <= 1'b0;
      unique case (state)
        IDLE: begin
          cmd_rdy <= 1'b1;
          if (cmd_hs) begin
            idx <= '0;
            if (bus.cmd_load_a) begin
              state   <= LOAD_A;
              cmd_rdy <= 1'b0;
              in_rdy  <= 1'b1;
            end else if (a_loaded) begin
              state   <= LOAD_W;
              cmd_rdy <= 1'b0;
              in_rdy  <= 1'b1;
            end else begin
              err_o <= 1'b1;
            end
          end
        end
        LOAD_A: begin
          if (in_hs) begin
            A_o[idx[AW-1:0]] <= bus.in_data;
            if (idx == A_LAST) begin
              idx      <= '0;
              a_loaded <= 1'b1;
              state    <= LOAD_W;
            end else begin
              idx <= idx + IW'(1);
            end
          end
        end
        LOAD_W: begin
          if (in_hs) begin
            W_o[idx[WW-1:0]] <= bus.in_data;
            if (idx == W_LAST) begin
              idx    <= '0;
              in_rdy <= 1'b0;
              en_o   <= 1'b1;
              state  <= FIRE;
            end else begin
              idx <= idx + IW'(1);
            end
          end
        end
        FIRE: begin
          tmr   <= '0;
          state <= WAIT;
        end
        WAIT: begin
          // a result in the last allowed cycle still beats the timeout
          if (arr_valid_i) begin
            for (int i = 0; i < SZ; i++)
              res_buf[i] <= O_i[i];
            idx     <= '0;
            res_vld <= 1'b1;
            res_lst <= (SZ == 1);
            state   <= DRAIN;
          end else if (tmr == T_LAST) begin
            tmr     <= '0;
            err_o   <= 1'b1;
            cmd_rdy <= 1'b1;
            state   <= IDLE;
          end else begin
            tmr <= tmr + TW'(1);
          end
        end
        DRAIN: begin
          if (res_hs) begin
            if (idx == W_LAST) begin
              idx     <= '0;
              res_vld <= 1'b0;
              res_lst <= 1'b0;
              cmd_rdy <= 1'b1;
              state   <= IDLE;
            end else begin
              idx     <= idx + IW'(1);
              res_lst <= (idx + IW'(1) == W_LAST);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
